cpu_seq_ctrl: RTL and testbench

Multicycle sequencer for the RV32I core datapath: steps each instruction through fetch, decode, optional memory access, and write-back.
- Handles the ACKI_n/ACKD_n bus wait-state handshakes and generates the PC, instruction-register and register-file write enables, plus the MREQ/WRITE strobes.
- Takes prioritized external interrupts at instruction boundaries via IACK_n.
- Sits between the decoder outputs and the top-level bus pins, replacing free-running single-cycle PC update.

---
 rtl/cpu_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multicycle fetch/decode/mem/write-back sequencer
// Bus wait-state handshakes, ACK timeout and single-level interrupt entry.
module cpu_seq_ctrl #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ACKI_n,
  input  logic       ACKD_n,
  input  logic [2:0] OINT_n,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       reg_write_req,
  input  logic       int_ret,
  output logic       ireq,
  output logic       ir_load,
  output logic       pc_we,
  output logic       pc_vec_sel,
  output logic       rf_we,
  output logic       MREQ,
  output logic       WRITE,
  output logic       IACK_n,
  output logic [2:0] int_level,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam bit TO_EN = (ACK_TIMEOUT > 0);
  localparam logic [CW-1:0] LAST = TO_EN ? CW'(ACK_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_INT    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          int_en, int_en_nxt;
  logic [2:0]    lvl_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= S_IDLE;
      cnt       <= '0;
      int_en    <= 1'b1;
      int_level <= 3'b000;
    end else begin
      cur       <= nxt;
      cnt       <= cnt_nxt;
      int_en    <= int_en_nxt;
      int_level <= lvl_nxt;
    end
  end

  always_comb begin
    nxt        = cur;
    cnt_nxt    = cnt;
    int_en_nxt = int_en;
    lvl_nxt    = int_level;
    ireq       = 1'b0;
    ir_load    = 1'b0;
    pc_we      = 1'b0;
    pc_vec_sel = 1'b0;
    rf_we      = 1'b0;
    MREQ       = 1'b0;
    WRITE      = 1'b0;
    IACK_n     = 1'b1;
    bus_err    = 1'b0;
    case (cur)
      S_IDLE: begin
        nxt     = S_FETCH;
        cnt_nxt = '0;
      end
      S_FETCH: begin
        ireq    = 1'b1;
        ir_load = ~ACKI_n;
        if (!ACKI_n)                  nxt = S_DECODE;
        else if (TO_EN && cnt == LAST) nxt = S_ERR;
        else                          cnt_nxt = cnt + CW'(1);
      end
      S_DECODE: begin
        if (is_load || is_store) begin
          nxt     = S_MEM;
          cnt_nxt = '0;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        MREQ  = 1'b1;
        WRITE = is_store;
        if (!ACKD_n)                  nxt = S_WB;
        else if (TO_EN && cnt == LAST) nxt = S_ERR;
        else                          cnt_nxt = cnt + CW'(1);
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = reg_write_req & ~is_store;
        if (int_ret) int_en_nxt = 1'b1;
        // Interrupt decision uses int_en as it stood before this int_ret.
        if (OINT_n != 3'b111 && int_en) begin
          nxt = S_INT;
        end else begin
          nxt     = S_FETCH;
          cnt_nxt = '0;
        end
      end
      S_INT: begin
        IACK_n     = 1'b0;
        pc_we      = 1'b1;
        pc_vec_sel = 1'b1;
        lvl_nxt    = ~OINT_n;
        int_en_nxt = 1'b0;
        nxt        = S_FETCH;
        cnt_nxt    = '0;
      end
      S_ERR: begin
        bus_err = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - table-driven scoreboard bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ACKI_n = 1'b1, ACKD_n = 1'b1;
  logic [2:0] OINT_n = 3'b111;
  logic       is_load = 1'b0, is_store = 1'b0, reg_write_req = 1'b0, int_ret = 1'b0;
  logic       ireq, ir_load, pc_we, pc_vec_sel, rf_we, MREQ, WRITE, IACK_n, bus_err;
  logic [2:0] int_level, state;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ACKI_n(ACKI_n), .ACKD_n(ACKD_n), .OINT_n(OINT_n),
    .is_load(is_load), .is_store(is_store), .reg_write_req(reg_write_req),
    .int_ret(int_ret), .ireq(ireq), .ir_load(ir_load), .pc_we(pc_we),
    .pc_vec_sel(pc_vec_sel), .rf_we(rf_we), .MREQ(MREQ), .WRITE(WRITE),
    .IACK_n(IACK_n), .int_level(int_level), .bus_err(bus_err), .state(state)
  );

  // strb bit order: ireq ir_load pc_we pc_vec_sel rf_we MREQ WRITE IACK_n
  typedef struct packed {
    logic       acki, ackd;
    logic [2:0] oint;
    logic       ld, st, rw, iret;
    logic [2:0] e_state;
    logic [7:0] e_strb;
    logic [2:0] e_lvl;
    logic       e_err;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] strb;
    logic [2:0] lvl;
    logic       err;
  } obs_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t v(logic acki, logic ackd, logic [2:0] oint, logic ld,
                             logic st, logic rw, logic iret, logic [2:0] es,
                             logic [7:0] eb, logic [2:0] el, logic ee);
    vec_t r;
    r = '{acki, ackd, oint, ld, st, rw, iret, es, eb, el, ee};
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st   = state;
    o.strb = {ireq, ir_load, pc_we, pc_vec_sel, rf_we, MREQ, WRITE, IACK_n};
    o.lvl  = int_level;
    o.err  = bus_err;
    return o;
  endfunction

  task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    obs_t e;
    // ALU op, zero wait
    vecs.push_back(v(1,1,3'b111,0,0,0,0, 3'd0, 8'b0000_0001, 3'd0, 0));
    vecs.push_back(v(0,1,3'b111,0,0,1,0, 3'd1, 8'b1100_0001, 3'd0, 0));
    vecs.push_back(v(1,0,3'b111,0,0,1,0, 3'd2, 8'b0000_0001, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,0,0,1,0, 3'd4, 8'b0010_1001, 3'd0, 0));
    // Load, 2 fetch waits, 3 data waits
    vecs.push_back(v(1,1,3'b111,0,0,0,0, 3'd1, 8'b1000_0001, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,0,0,0,0, 3'd1, 8'b1000_0001, 3'd0, 0));
    vecs.push_back(v(0,1,3'b111,0,0,0,0, 3'd1, 8'b1100_0001, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,1,0,1,0, 3'd2, 8'b0000_0001, 3'd0, 0));
    vecs.push_back(v(0,1,3'b111,1,0,1,0, 3'd3, 8'b0000_0101, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,1,0,1,0, 3'd3, 8'b0000_0101, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,1,0,1,0, 3'd3, 8'b0000_0101, 3'd0, 0));
    vecs.push_back(v(1,0,3'b111,1,0,1,0, 3'd3, 8'b0000_0101, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,1,0,1,0, 3'd4, 8'b0010_1001, 3'd0, 0));
    // Store, zero wait: rf_we masked
    vecs.push_back(v(0,1,3'b111,0,1,1,0, 3'd1, 8'b1100_0001, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,0,1,1,0, 3'd2, 8'b0000_0001, 3'd0, 0));
    vecs.push_back(v(1,0,3'b111,0,1,1,0, 3'd3, 8'b0000_0111, 3'd0, 0));
    vecs.push_back(v(1,1,3'b111,0,1,1,0, 3'd4, 8'b0010_0001, 3'd0, 0));
    // Interrupt 101 taken after WB
    vecs.push_back(v(0,1,3'b101,0,0,0,0, 3'd1, 8'b1100_0001, 3'd0, 0));
    vecs.push_back(v(1,1,3'b101,0,0,0,0, 3'd2, 8'b0000_0001, 3'd0, 0));
    vecs.push_back(v(1,1,3'b101,0,0,0,0, 3'd4, 8'b0010_0001, 3'd0, 0));
    vecs.push_back(v(1,1,3'b101,0,0,0,0, 3'd5, 8'b0011_0000, 3'd0, 0));
    // Second request ignored until int_ret completes WB
    vecs.push_back(v(0,1,3'b110,0,0,0,0, 3'd1, 8'b1100_0001, 3'd2, 0));
    vecs.push_back(v(1,1,3'b110,0,0,0,0, 3'd2, 8'b0000_0001, 3'd2, 0));
    vecs.push_back(v(1,1,3'b110,0,0,0,0, 3'd4, 8'b0010_0001, 3'd2, 0));
    vecs.push_back(v(0,1,3'b110,0,0,0,1, 3'd1, 8'b1100_0001, 3'd2, 0));
    vecs.push_back(v(1,1,3'b110,0,0,0,1, 3'd2, 8'b0000_0001, 3'd2, 0));
    vecs.push_back(v(1,1,3'b110,0,0,0,1, 3'd4, 8'b0010_0001, 3'd2, 0));
    vecs.push_back(v(0,1,3'b110,0,0,0,0, 3'd1, 8'b1100_0001, 3'd2, 0));
    vecs.push_back(v(1,1,3'b110,0,0,0,0, 3'd2, 8'b0000_0001, 3'd2, 0));
    vecs.push_back(v(1,1,3'b110,0,0,0,0, 3'd4, 8'b0010_0001, 3'd2, 0));
    vecs.push_back(v(1,1,3'b110,0,0,0,0, 3'd5, 8'b0011_0000, 3'd2, 0));
    // Load with ACKD_n stuck high: ERR after 4 edges, sticky
    vecs.push_back(v(0,1,3'b111,0,0,0,0, 3'd1, 8'b1100_0001, 3'd1, 0));
    vecs.push_back(v(1,1,3'b111,1,0,1,0, 3'd2, 8'b0000_0001, 3'd1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1,1,3'b111,1,0,1,0, 3'd3, 8'b0000_0101, 3'd1, 0));
    vecs.push_back(v(1,0,3'b111,1,0,1,0, 3'd6, 8'b0000_0001, 3'd1, 1));
    vecs.push_back(v(0,0,3'b111,1,0,1,0, 3'd6, 8'b0000_0001, 3'd1, 1));

    #2;
    chk("reset_state", 15'(observe()), {3'd0, 8'b0000_0001, 3'd0, 1'b0});
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      {ACKI_n, ACKD_n, OINT_n, is_load, is_store, reg_write_req, int_ret} =
        {vecs[i].acki, vecs[i].ackd, vecs[i].oint, vecs[i].ld, vecs[i].st,
         vecs[i].rw, vecs[i].iret};
      sb.push_back('{vecs[i].e_state, vecs[i].e_strb, vecs[i].e_lvl, vecs[i].e_err});
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d", i), 15'(observe()), 15'(e));
      @(negedge clk);
    end

    // Reset clears ERR and the latched level
    rst = 1'b0;
    {ACKI_n, ACKD_n, OINT_n, is_load, is_store, reg_write_req, int_ret} = {2'b11, 3'b111, 4'b0};
    #1;
    chk("rst_from_err", 15'(observe()), {3'd0, 8'b0000_0001, 3'd0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ACKI_n = 1'b0;
    #1;
    chk("fetch_after_rst", 15'(observe()), {3'd1, 8'b1100_0001, 3'd0, 1'b0});
    @(negedge clk);
    ACKI_n = 1'b1; is_load = 1'b1; reg_write_req = 1'b1;
    @(negedge clk);
    #1;
    chk("mem_wait", 15'(observe()), {3'd3, 8'b0000_0101, 3'd0, 1'b0});
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_mem", 15'(observe()), {3'd0, 8'b0000_0001, 3'd0, 1'b0});
    @(negedge clk);
    rst = 1'b1; is_load = 1'b0; reg_write_req = 1'b0;
    #1;
    chk("idle_after_rel", 15'(observe()), {3'd0, 8'b0000_0001, 3'd0, 1'b0});
    @(negedge clk);
    #1;
    chk("fetch_after_rel", 15'(observe()), {3'd1, 8'b1000_0001, 3'd0, 1'b0});
    // ACKI_n held high: 3 edges still FETCH, 4th edge enters ERR
    repeat (3) @(negedge clk);
    #1;
    chk("fetch_wait3", 15'(observe()), {3'd1, 8'b1000_0001, 3'd0, 1'b0});
    @(negedge clk);
    #1;
    chk("fetch_timeout", 15'(observe()), {3'd6, 8'b0000_0001, 3'd0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
